// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter in front of a single-ported byte memory. Port A (CPU) and
// port B (host loader) each issue one transaction at a time. Every granted
// transaction walks IDLE -> ISSUE -> WAIT -> ACK, so a transaction always
// takes exactly four cycles from grant to acknowledge.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request, direction, address, write data
//   a_ack/a_rdata               port A one-cycle completion pulse and read data
//   b_req/b_we/b_addr/b_wdata   port B request, direction, address, write data
//   b_ack/b_rdata               port B one-cycle completion pulse and read data
//   b_lock                      port B exclusive-ownership request
//   mem_raddr/mem_waddr         registered memory read/write addresses
//   mem_write                   one-cycle memory write strobe
//   mem_data_in                 write data to memory
//   mem_data_out                memory read data, valid one cycle after mem_raddr
//   owner                       0 = A, 1 = B; port of the current/last transaction

module mem_arbiter #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [7:0]            a_wdata,
  output logic                  a_ack,
  output logic [7:0]            a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_ack,
  output logic [7:0]            b_rdata,
  input  logic                  b_lock,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // prefer_b: round-robin pointer, set when A was served last.
  // mask_valid: high only in the first IDLE cycle after ACK; it hides the
  // lingering request of the port that was just served (identified by owner).
  logic prefer_b;
  logic mask_valid;
  logic cur_we;

  logic a_eligible;
  logic b_eligible;
  logic grant_valid;
  logic grant_b;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_wdata;

  // Arbitration. While B holds the lock and keeps requesting, A is never
  // granted; if B's request is masked that cycle nobody is granted, so A
  // cannot sneak in between locked B transactions.
  always_comb begin
    a_eligible  = a_req && !(mask_valid && !owner);
    b_eligible  = b_req && !(mask_valid && owner);
    grant_valid = 1'b0;
    grant_b     = 1'b0;
    if (b_lock && b_req) begin
      grant_valid = b_eligible;
      grant_b     = 1'b1;
    end else if (a_eligible && b_eligible) begin
      grant_valid = 1'b1;
      grant_b     = prefer_b;
    end else if (a_eligible) begin
      grant_valid = 1'b1;
      grant_b     = 1'b0;
    end else if (b_eligible) begin
      grant_valid = 1'b1;
      grant_b     = 1'b1;
    end
  end

  // Request fields of the winning port.
  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (grant_b) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. Memory address/data are loaded on the grant edge so
  // they are visible during ISSUE; read data is captured at the end of WAIT
  // and the ack is raised at the same edge so both appear together in ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= 1'b0;
      prefer_b    <= 1'b0;
      mask_valid  <= 1'b0;
      cur_we      <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= 8'h00;
      b_rdata     <= 8'h00;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_write   <= 1'b0;
      mem_data_in <= 8'h00;
    end else begin
      mem_write <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      case (state)
        IDLE: begin
          mask_valid <= 1'b0;
          if (grant_valid) begin
            owner    <= grant_b;
            prefer_b <= !grant_b;
            cur_we   <= sel_we;
            if (sel_we) begin
              mem_waddr   <= sel_addr;
              mem_data_in <= sel_wdata;
              mem_write   <= 1'b1;
            end else begin
              mem_raddr <= sel_addr;
            end
          end
        end
        WAIT: begin
          if (!cur_we) begin
            if (owner) begin
              b_rdata <= mem_data_out;
            end else begin
              a_rdata <= mem_data_out;
            end
          end
          if (owner) begin
            b_ack <= 1'b1;
          end else begin
            a_ack <= 1'b1;
          end
        end
        ACK: begin
          mask_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
